// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles little-endian instructions, writes them
// sequentially from address 0, verifies an XOR checksum and then pulses start.
module program_loader #(
  parameter int INSTRUCTION_BYTES = 4,
  parameter int ADDRESS_WIDTH     = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_data,
  output logic                           write_enable,
  output logic [ADDRESS_WIDTH-1:0]       write_address,
  output logic [8*INSTRUCTION_BYTES-1:0] write_data,
  output logic                           start,
  output logic                           busy,
  output logic [7:0]                     loaded_count,
  output logic                           error,
  output logic [2:0]                     debug_state
);
  localparam int IW = 8 * INSTRUCTION_BYTES;
  localparam int BW = (INSTRUCTION_BYTES > 1) ? $clog2(INSTRUCTION_BYTES) : 1;
  localparam logic [7:0] HEADER = 8'hA5;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; the
  // source holds in_data stable while in_valid is high and in_ready is low.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_START = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [BW-1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]               count_q, count_d;
  logic [7:0]               csum_q, csum_d;
  logic [IW-1:0]            asm_q, asm_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [IW-1:0]            wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic [7:0]               loaded_q, loaded_d;
  logic                     error_q, error_d;
  logic                     xfer;
  logic                     last_byte;
  logic                     last_instr;
  logic                     count_ok;

  assign in_ready   = !reset && (state_q != S_START);
  assign xfer       = in_valid && in_ready;
  assign last_byte  = (32'(byte_cnt_q) == INSTRUCTION_BYTES - 1);
  // Compared in 32 bits so a full-memory frame ends at the all-ones address.
  assign last_instr = ((32'(idx_q) + 32'd1) == 32'(count_q));
  assign count_ok   = (in_data != 8'd0) &&
                      ({56'd0, in_data} <= (64'd1 << ADDRESS_WIDTH));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    count_d    = count_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    loaded_d   = loaded_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (xfer && (in_data == HEADER)) begin
          state_d    = S_COUNT;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          csum_d     = 8'd0;
          byte_cnt_d = '0;
          idx_d      = '0;
          asm_d      = '0;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if (count_ok) begin
            count_d = in_data;
            state_d = S_DATA;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          csum_d = csum_q ^ in_data;
          if (last_byte) begin
            byte_cnt_d = '0;
            we_d       = 1'b1;
            waddr_d    = idx_q;
            wdata_d    = asm_d;
            if (last_instr) state_d = S_CHECK;
            else            idx_d   = idx_q + ADDRESS_WIDTH'(1);
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (in_data == csum_q) begin
            loaded_d = count_q;
            state_d  = S_START;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_START: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      idx_q      <= '0;
      count_q    <= 8'd0;
      csum_q     <= 8'd0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      loaded_q   <= 8'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      error_q    <= error_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign start         = (state_q == S_START) && !reset;
  assign busy          = busy_q;
  assign loaded_count  = loaded_q;
  assign error         = error_q;
  assign debug_state   = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: spec vectors from a table, hand-written corner
// sequences, and randomized frames checked against a frame-level parser model.
module tb_program_loader;
  localparam int IB = 4;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        write_enable;
  logic [AW-1:0] write_address;
  logic [8*IB-1:0] write_data;
  logic        start;
  logic        busy;
  logic [7:0]  loaded_count;
  logic        error;
  logic [2:0]  debug_state;

  program_loader #(.INSTRUCTION_BYTES(IB), .ADDRESS_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .start         (start),
    .busy          (busy),
    .loaded_count  (loaded_count),
    .error         (error),
    .debug_state   (debug_state)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [AW+8*IB-1:0] exp_q[$];
  logic [AW+8*IB-1:0] got_q[$];
  int   start_cnt = 0;
  int   ready_viol = 0;
  int   we_viol = 0;
  int   busy_viol = 0;
  logic we_prev = 1'b0;
  logic [7:0] m_count = 8'd0;
  logic       m_error = 1'b0;

  always @(negedge clock) begin
    if (write_enable) got_q.push_back({write_address, write_data});
    if (start) start_cnt++;
    if (!reset && (in_ready == start)) ready_viol++;
    if (write_enable && we_prev) we_viol++;
    if (start && busy) busy_viol++;
    we_prev = write_enable;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Scans a complete byte stream frame by frame; fills exp_q with the writes
  // that must appear and tracks the sticky error / loaded count.
  task automatic model_stream(input logic [7:0] s[$], output int starts);
    int i;
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    starts = 0;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      m_error = 1'b0;
      n = int'(s[i+1]);
      if (n == 0 || n > (1 << AW)) begin
        m_error = 1'b1;
        i += 2;
        continue;
      end
      x = 8'd0;
      for (int k = 0; k < n; k++) begin
        w = 32'd0;
        for (int j = 0; j < IB; j++) begin
          w = w | (32'(s[i + 2 + IB*k + j]) << (8*j));
          x = x ^ s[i + 2 + IB*k + j];
        end
        exp_q.push_back({AW'(k), w});
      end
      if (s[i + 2 + IB*n] == x) begin
        m_count = 8'(n);
        starts++;
      end else begin
        m_error = 1'b1;
      end
      i += 3 + IB*n;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int idle_pct);
    int waited;
    while (int'($urandom_range(99)) < idle_pct) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: in_ready still 0 after %0d cycles, required 1", waited);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_write"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
  endtask

  task automatic run_stream(input string tag, input logic [7:0] s[$], input int idle_pct);
    int s0;
    int exp_starts;
    got_q.delete();
    exp_q.delete();
    s0 = start_cnt;
    model_stream(s, exp_starts);
    foreach (s[k]) send_byte(s[k], idle_pct);
    settle();
    compare_writes(tag);
    check({tag, "_starts"}, 64'(start_cnt - s0), 64'(exp_starts));
    check({tag, "_error"}, 64'(error), 64'(m_error));
    check({tag, "_count"}, 64'(loaded_count), 64'(m_count));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          off;
    int          len;
    logic        exp_start;
    logic        exp_error;
    logic [7:0]  exp_count;
    int          exp_nw;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] pool[$];
  logic [7:0] fr[$];
  logic [7:0] dm[5];
  logic [7:0] x;
  logic [7:0] d;
  int         s0;
  int         n;

  initial begin
    pool = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    pool = {pool, 8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    pool = {pool, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    pool = {pool, 8'hA5, 8'h00};
    vecs[0] = '{0,  11, 1'b1, 1'b0, 8'd2, 2, 32'h44332211, 32'h88776655};
    vecs[1] = '{11, 11, 1'b0, 1'b1, 8'd2, 2, 32'h44332211, 32'h88776655};
    vecs[2] = '{22, 10, 1'b1, 1'b0, 8'd1, 1, 32'hEFBEADDE, 32'h0};
    vecs[3] = '{32, 2,  1'b0, 1'b1, 8'd1, 0, 32'h0,        32'h0};

    // reset values
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_we", 64'(write_enable), 64'(0));
    check("rst_addr", 64'(write_address), 64'(0));
    check("rst_data", 64'(write_data), 64'(0));
    check("rst_start", 64'(start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(loaded_count), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    #1;

    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      s0 = start_cnt;
      for (int k = 0; k < vecs[v].len; k++) send_byte(pool[vecs[v].off + k], 0);
      check($sformatf("v%0d_start_latency", v), 64'(start), 64'(vecs[v].exp_start));
      check($sformatf("v%0d_error", v), 64'(error), 64'(vecs[v].exp_error));
      check($sformatf("v%0d_busy", v), 64'(busy), 64'(0));
      settle();
      check($sformatf("v%0d_count", v), 64'(loaded_count), 64'(vecs[v].exp_count));
      check($sformatf("v%0d_starts", v), 64'(start_cnt - s0), 64'(vecs[v].exp_start));
      check($sformatf("v%0d_nwrites", v), 64'(got_q.size()), 64'(vecs[v].exp_nw));
      if (vecs[v].exp_nw > 0 && got_q.size() > 0)
        check($sformatf("v%0d_w0", v), 64'(got_q[0]), 64'({8'h00, vecs[v].exp_w0}));
      if (vecs[v].exp_nw > 1 && got_q.size() > 1)
        check($sformatf("v%0d_w1", v), 64'(got_q[1]), 64'({8'h01, vecs[v].exp_w1}));
    end

    // header clears sticky error and raises busy the next cycle
    send_byte(8'hA5, 0);
    check("hdr_error_clear", 64'(error), 64'(0));
    check("hdr_busy_rise", 64'(busy), 64'(1));
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_byte(8'h22, 0);
    check("hdr_seq_start", 64'(start), 64'(1));
    settle();

    // reset after 5 data bytes of a 2-instruction frame
    got_q.delete();
    s0 = start_cnt;
    for (int k = 0; k < 5; k++) dm[k] = 8'($urandom);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 5; k++) send_byte(dm[k], 0);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    check("midrst_we", 64'(write_enable), 64'(0));
    check("midrst_addr", 64'(write_address), 64'(0));
    check("midrst_data", 64'(write_data), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_count", 64'(loaded_count), 64'(0));
    check("midrst_error", 64'(error), 64'(0));
    reset = 1'b0;
    m_count = 8'd0;
    m_error = 1'b0;
    settle();
    check("midrst_nwrites", 64'(got_q.size()), 64'(1));
    if (got_q.size() > 0)
      check("midrst_w0", 64'(got_q[0]), 64'({8'h00, dm[3], dm[2], dm[1], dm[0]}));
    check("midrst_starts", 64'(start_cnt - s0), 64'(0));

    // 3-instruction frame, back-to-back then with ~50% in_valid gaps
    fr = {8'hA5, 8'h03};
    x = 8'd0;
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      fr.push_back(d);
      x = x ^ d;
    end
    fr.push_back(x);
    run_stream("b2b3", fr, 0);
    run_stream("gap3", fr, 50);

    // randomized streams: junk prefix, random counts, occasional bad checksum
    for (int f = 0; f < 10; f++) begin
      fr.delete();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        d = 8'($urandom);
        if (d == 8'hA5) d = 8'h5A;
        fr.push_back(d);
      end
      n = int'($urandom_range(0, 5));
      fr.push_back(8'hA5);
      fr.push_back(8'(n));
      if (n > 0) begin
        x = 8'd0;
        for (int k = 0; k < IB*n; k++) begin
          d = 8'($urandom);
          fr.push_back(d);
          x = x ^ d;
        end
        if ($urandom_range(3) == 0) x = x ^ 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      run_stream($sformatf("rand%0d", f), fr, int'($urandom_range(0, 60)));
    end

    check("ready_only_low_in_start", 64'(ready_viol), 64'(0));
    check("no_back_to_back_writes", 64'(we_viol), 64'(0));
    check("busy_low_with_start", 64'(busy_viol), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
